// File: rtl/hslp_pkg.sv
// Shared constants and types for the approximate-multiplier error meter.
package hslp_pkg;

   localparam int unsigned OP_W   = 8;
   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned ED_W   = 2 * OP_W + 1;
   localparam int unsigned ACC_W  = 4 * OP_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/err_accum.sv
// Stage-2 accumulator bank: error count, summed |ed|, summed ed and max |ed|.
module err_accum #(
   parameter int unsigned OP_W  = 8,
   parameter int unsigned ACC_W = 4 * OP_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     valid,
   input  logic signed [2*OP_W:0]   ed,
   output logic [2*OP_W:0]          err_cnt,
   output logic [ACC_W-1:0]         sum_aed,
   output logic signed [ACC_W:0]    sum_ed,
   output logic [2*OP_W-1:0]        max_aed
);

   localparam int unsigned PW = 2 * OP_W;
   localparam int unsigned EW = 2 * OP_W + 1;
   localparam int unsigned CW = 2 * OP_W + 1;
   localparam int unsigned SW = ACC_W + 1;

   logic [EW-1:0] neg_c;
   logic [PW-1:0] aed_c;
   logic [SW-1:0] ed_ext_c;

   // |ed| always fits PW bits: ed spans [-(2^OP_W-1)^2, 2^PW-1]
   always_comb begin
      neg_c    = EW'(-ed);
      aed_c    = ed[EW-1] ? neg_c[PW-1:0] : ed[PW-1:0];
      ed_ext_c = {{(SW-EW){ed[EW-1]}}, ed};
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_cnt <= '0;
         sum_aed <= '0;
         sum_ed  <= '0;
         max_aed <= '0;
      end else if (valid) begin
         err_cnt <= err_cnt + CW'(ed != '0);
         sum_aed <= sum_aed + ACC_W'(aed_c);
         sum_ed  <= sum_ed + ed_ext_c;
         if (aed_c > max_aed) max_aed <= aed_c;
      end
   end

endmodule

// File: rtl/hslp_err_meter.sv
// Sweeps all operand pairs through an external approximate multiplier and
// accumulates error statistics against the exact product.
module hslp_err_meter #(
   parameter int unsigned OP_W  = hslp_pkg::OP_W,
   parameter int unsigned ACC_W = 4 * OP_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [OP_W-1:0]          op_a,
   output logic [OP_W-1:0]          op_b,
   input  logic [2*OP_W-1:0]        approx_prod,
   output logic                     busy,
   output logic                     done,
   output logic [2*OP_W:0]          err_cnt,
   output logic [ACC_W-1:0]         sum_aed,
   output logic signed [ACC_W:0]    sum_ed,
   output logic [2*OP_W-1:0]        max_aed
);

   import hslp_pkg::*;

   localparam int unsigned PW = 2 * OP_W;
   localparam int unsigned EW = 2 * OP_W + 1;

   state_t               state;
   state_t               state_nx;
   logic [PW-1:0]        cnt;
   logic                 last;
   logic                 accept;
   logic                 busy_d;
   logic                 done_d;
   logic                 s1_valid;
   logic signed [EW-1:0] s1_ed;
   logic [PW-1:0]        exact_c;
   logic signed [EW-1:0] ed_c;

   assign last = (state == SWEEP) && (cnt == '1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = SWEEP;
         SWEEP:   if (last)  state_nx = DRAIN;
         DRAIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      accept = (state == IDLE) && start;
      busy_d = (state_nx != IDLE);
      done_d = (state == DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
      end
   end

   // Pair counter doubles as the operand register; op_b is the fast half
   always_ff @(posedge clk) begin
      if (rst || accept)        cnt <= '0;
      else if (state == SWEEP)  cnt <= cnt + PW'(1);
   end

   assign op_a = cnt[PW-1:OP_W];
   assign op_b = cnt[OP_W-1:0];

   always_comb begin
      exact_c = PW'(op_a) * PW'(op_b);
      ed_c    = $signed(EW'(approx_prod) - EW'(exact_c));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_ed    <= '0;
      end else begin
         s1_valid <= (state == SWEEP);
         if (state == SWEEP) s1_ed <= ed_c;
      end
   end

   err_accum #(
      .OP_W  (OP_W),
      .ACC_W (ACC_W)
   ) u_accum (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .valid   (s1_valid),
      .ed      (s1_ed),
      .err_cnt (err_cnt),
      .sum_aed (sum_aed),
      .sum_ed  (sum_ed),
      .max_aed (max_aed)
   );

endmodule

// File: doc/hslp_err_meter.md
# hslp_err_meter

Sequential error-characterisation engine for the 8x8 approximate multipliers. It sits on the opposite side of the multiplier's operand/product interface: it drives `op_a`/`op_b` into an external combinational approximate multiplier (e.g. `HSLP_2222`) and reads back its product. On each `start` it sweeps all 2^(2·OP_W) operand pairs, one pair per cycle. It compares each returned product against an internally computed exact product and accumulates error statistics (error count, summed absolute error, summed signed error, maximum absolute error) for read-out.

## Interface

- `OP_W`, default 8, operand width; pair count = 2^(2·OP_W).
- `ACC_W`, default 4·OP_W (32), width of the absolute-error sum.
- `clk`  in  1  sole clock; everything on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `op_a`  out  OP_W  operand A to multiplier; registered.
- `op_b`  out  OP_W  operand B to multiplier; registered.
- `approx_prod`  in  2·OP_W  multiplier product for current `op_a`/`op_b`; combinational return path.
- `busy`  out  1  high in SWEEP and DRAIN.
- `done`  out  1  one-cycle pulse; results final.
- `err_cnt`  out  2·OP_W+1  pairs with approx ≠ exact.
- `sum_aed`  out  ACC_W  Σ|approx − exact|.
- `sum_ed`  out  ACC_W+1 signed  Σ(approx − exact).
- `max_aed`  out  2·OP_W  max |approx − exact|.

## Operation

- States: IDLE → SWEEP → DRAIN → IDLE.
- IDLE with `start`=1:
  - clear the pair counter, all accumulators and the stage-1 valid bit;
  - go to SWEEP.
- `start` in SWEEP/DRAIN is ignored.
- Pair counter is 2·OP_W bits: `op_a` is the upper half, `op_b` the lower half, so `op_b` varies fastest. It increments every SWEEP cycle.
- SWEEP, every cycle, stage 1 registers:
  - ed = approx_prod − op_a·op_b, signed, 2·OP_W+1 bits;
  - a valid bit.
- Stage 2 (accumulate, when stage-1 valid):
  - err_cnt += (ed≠0);
  - sum_aed += |ed|;
  - sum_ed += ed (sign-extended);
  - max_aed = max(max_aed, |ed|).
- Counter at all-ones in SWEEP → DRAIN next cycle; counter wraps to 0 and is not re-presented.
- DRAIN lasts one cycle, then IDLE with `done`=1 for that one cycle.
- Widths are sized for the worst case, so accumulators never overflow. For OP_W=8, Σ|ed| ≤ 65025·65536 < 2^32.
- Results hold from `done` until the next accepted `start`, or reset.
- `rst` at any time, including mid-sweep: state IDLE, all outputs and accumulators 0, partial results discarded.

## Timing

- Reset values: `op_a`=`op_b`=0, `busy`=0, `done`=0, `err_cnt`=`sum_aed`=`sum_ed`=`max_aed`=0.
- Edge numbering: edge t starts cycle t. `start` high during cycle N−1 is accepted at edge N.
- Cycle N: `busy`=1, `op_a`=`op_b`=0.
- Pair k (k = 0…2^(2·OP_W)−1) is presented during cycle N+k.
- `approx_prod` is sampled at edge N+k+1 and accumulated at edge N+k+2.
- For OP_W=8:
  - last pair in cycle N+65535;
  - DRAIN in cycle N+65536;
  - `busy`=0 and `done`=1 in cycle N+65537.
- Sweep latency is 2^(2·OP_W)+1 cycles from acceptance to `done`.
- `start` during the `done` cycle is accepted (state is IDLE).

## Structure

- Shared package `hslp_pkg`: `OP_W`, state enum (IDLE/SWEEP/DRAIN), derived width constants.
- Sub-module `err_accum`: stage-2 accumulator bank with inputs clear, valid, ed.
- FSM, counter and stage-1 error logic live in the top.

## Test plan

- Exact multiplier stub (approx = a·b), OP_W=8:
  - all result outputs stay 0;
  - `busy` high for 65537 cycles;
  - `done` pulses once in cycle N+65537.
- Stub approx=0:
  - err_cnt=65025;
  - sum_aed=1065369600;
  - sum_ed=−1065369600;
  - max_aed=65025.
- Stub approx=a·b+1:
  - err_cnt=65536;
  - sum_aed=65536;
  - sum_ed=+65536;
  - max_aed=1.
- Ordering check, monitoring `op_a`/`op_b`:
  - cycle N+1 shows (0,1);
  - cycle N+256 shows (1,0);
  - cycle N+65535 shows (255,255).
- `start` re-pulsed at cycle N+100 → ignored; `done` still at N+65537 with unchanged results.
- `rst` at cycle N+1000, then a fresh `start`:
  - all outputs 0 after reset;
  - second sweep matches the undisturbed-sweep values.
